// File: rtl/exp6_unidade_controle.sv
// rtl/exp6_unidade_controle.sv - Moore control FSM sequencing the memory game datapath
// Replays the stored sequence each round, then collects and checks the player's moves.
module exp6_unidade_controle #(
  parameter bit HABILITA_TIMEOUT = 1'b1,
  parameter bit ECO_JOGADA       = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       jogada_feita,
  input  logic       jogada_correta,
  input  logic       enderecoIgualRodada,
  input  logic       fimCR,
  input  logic       fimL,
  input  logic       timeout,
  output logic       zeraCR,
  output logic       contaCR,
  output logic       zeraE,
  output logic       contaE,
  output logic       limpaRC,
  output logic       registraRC,
  output logic       zeraLeds,
  output logic       registraLeds,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraT,
  output logic       contaT,
  output logic       led_selector,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    MOSTRA_LED     = 4'h2,
    ESPERA_LED     = 4'h3,
    APAGA_LED      = 4'h4,
    PROXIMO_LED    = 4'h5,
    INICIA_JOGADAS = 4'h6,
    ESPERA_JOGADA  = 4'h7,
    REGISTRA       = 4'h8,
    COMPARACAO     = 4'h9,
    PROXIMA_JOGADA = 4'hA,
    PROXIMA_RODADA = 4'hB,
    FIM_ACERTOU    = 4'hC,
    FIM_ERROU      = 4'hD,
    FIM_TIMEOUT    = 4'hE,
    INVALIDO       = 4'hF
  } estado_t;

  estado_t state_q, state_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INICIAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INICIAL:        if (jogar) state_d = PREPARACAO;
      PREPARACAO:     state_d = MOSTRA_LED;
      MOSTRA_LED:     state_d = ESPERA_LED;
      ESPERA_LED:     if (fimL) state_d = APAGA_LED;
      APAGA_LED:      state_d = enderecoIgualRodada ? INICIA_JOGADAS : PROXIMO_LED;
      PROXIMO_LED:    state_d = MOSTRA_LED;
      INICIA_JOGADAS: state_d = ESPERA_JOGADA;
      // A move arriving together with the timeout still counts.
      ESPERA_JOGADA: begin
        if (jogada_feita) begin
          state_d = REGISTRA;
        end else if (timeout && HABILITA_TIMEOUT) begin
          state_d = FIM_TIMEOUT;
        end
      end
      REGISTRA:       state_d = COMPARACAO;
      COMPARACAO: begin
        if (!jogada_correta) begin
          state_d = FIM_ERROU;
        end else if (!enderecoIgualRodada) begin
          state_d = PROXIMA_JOGADA;
        end else if (fimCR) begin
          state_d = FIM_ACERTOU;
        end else begin
          state_d = PROXIMA_RODADA;
        end
      end
      PROXIMA_JOGADA: state_d = ESPERA_JOGADA;
      PROXIMA_RODADA: state_d = MOSTRA_LED;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: if (jogar) state_d = PREPARACAO;
      default:        state_d = INICIAL;
    endcase
  end

  always_comb begin
    zeraCR       = 1'b0;
    contaCR      = 1'b0;
    zeraE        = 1'b0;
    contaE       = 1'b0;
    limpaRC      = 1'b0;
    registraRC   = 1'b0;
    zeraLeds     = 1'b0;
    registraLeds = 1'b0;
    zeraL        = 1'b0;
    contaL       = 1'b0;
    zeraT        = 1'b0;
    contaT       = 1'b0;
    led_selector = 1'b0;
    ganhou       = 1'b0;
    perdeu       = 1'b0;
    pronto       = 1'b0;
    db_timeout   = 1'b0;
    case (state_q)
      PREPARACAO: begin
        zeraCR   = 1'b1;
        zeraE    = 1'b1;
        limpaRC  = 1'b1;
        zeraLeds = 1'b1;
        zeraL    = 1'b1;
        zeraT    = 1'b1;
      end
      MOSTRA_LED: begin
        registraLeds = 1'b1;
        led_selector = 1'b1;
        zeraL        = 1'b1;
      end
      ESPERA_LED: begin
        contaL       = 1'b1;
        led_selector = 1'b1;
      end
      APAGA_LED: begin
        zeraLeds = 1'b1;
        zeraL    = 1'b1;
      end
      PROXIMO_LED: contaE = 1'b1;
      INICIA_JOGADAS: begin
        zeraE   = 1'b1;
        zeraT   = 1'b1;
        limpaRC = 1'b1;
      end
      ESPERA_JOGADA: contaT = 1'b1;
      REGISTRA: begin
        registraRC   = 1'b1;
        zeraT        = 1'b1;
        registraLeds = ECO_JOGADA;
      end
      PROXIMA_JOGADA: begin
        contaE   = 1'b1;
        zeraLeds = 1'b1;
      end
      PROXIMA_RODADA: begin
        contaCR  = 1'b1;
        zeraE    = 1'b1;
        zeraLeds = 1'b1;
        limpaRC  = 1'b1;
      end
      FIM_ACERTOU: begin
        ganhou = 1'b1;
        pronto = 1'b1;
      end
      FIM_ERROU: begin
        perdeu = 1'b1;
        pronto = 1'b1;
      end
      FIM_TIMEOUT: begin
        perdeu     = 1'b1;
        pronto     = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = state_q;

endmodule

// File: tb/tb_exp6_unidade_controle.sv
// tb/tb_exp6_unidade_controle.sv - scoreboard bench for the memory game control FSM
module tb_exp6_unidade_controle;

  logic clock = 1'b0;
  logic reset;
  logic jogar, jogada_feita, jogada_correta, eq, fimCR, fimL, timeout;
  logic jogar1, timeout1, fimL1, eq1;

  wire [16:0] o0, o1;
  wire [3:0]  st0, st1;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  event async_ev;
  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  exp6_unidade_controle dut0 (
    .clock(clock), .reset(reset), .jogar(jogar), .jogada_feita(jogada_feita),
    .jogada_correta(jogada_correta), .enderecoIgualRodada(eq), .fimCR(fimCR),
    .fimL(fimL), .timeout(timeout),
    .zeraCR(o0[16]), .contaCR(o0[15]), .zeraE(o0[14]), .contaE(o0[13]),
    .limpaRC(o0[12]), .registraRC(o0[11]), .zeraLeds(o0[10]), .registraLeds(o0[9]),
    .zeraL(o0[8]), .contaL(o0[7]), .zeraT(o0[6]), .contaT(o0[5]),
    .led_selector(o0[4]), .ganhou(o0[3]), .perdeu(o0[2]), .pronto(o0[1]),
    .db_timeout(o0[0]), .db_estado(st0)
  );

  exp6_unidade_controle #(.HABILITA_TIMEOUT(1'b0)) dut1 (
    .clock(clock), .reset(reset), .jogar(jogar1), .jogada_feita(1'b0),
    .jogada_correta(1'b0), .enderecoIgualRodada(eq1), .fimCR(1'b0),
    .fimL(fimL1), .timeout(timeout1),
    .zeraCR(o1[16]), .contaCR(o1[15]), .zeraE(o1[14]), .contaE(o1[13]),
    .limpaRC(o1[12]), .registraRC(o1[11]), .zeraLeds(o1[10]), .registraLeds(o1[9]),
    .zeraL(o1[8]), .contaL(o1[7]), .zeraT(o1[6]), .contaT(o1[5]),
    .led_selector(o1[4]), .ganhou(o1[3]), .perdeu(o1[2]), .pronto(o1[1]),
    .db_timeout(o1[0]), .db_estado(st1)
  );

  // Strobe pattern each state must present, bit order matching o0/o1.
  function automatic logic [16:0] exp_out(input logic [3:0] s);
    logic [16:0] v;
    v = '0;
    case (s)
      4'h1: begin v[16] = 1; v[14] = 1; v[12] = 1; v[10] = 1; v[8] = 1; v[6] = 1; end
      4'h2: begin v[9] = 1; v[4] = 1; v[8] = 1; end
      4'h3: begin v[7] = 1; v[4] = 1; end
      4'h4: begin v[10] = 1; v[8] = 1; end
      4'h5: v[13] = 1;
      4'h6: begin v[14] = 1; v[6] = 1; v[12] = 1; end
      4'h7: v[5] = 1;
      4'h8: begin v[11] = 1; v[6] = 1; v[9] = 1; end
      4'hA: begin v[13] = 1; v[10] = 1; end
      4'hB: begin v[15] = 1; v[14] = 1; v[10] = 1; v[12] = 1; end
      4'hC: begin v[3] = 1; v[1] = 1; end
      4'hD: begin v[2] = 1; v[1] = 1; end
      4'hE: begin v[2] = 1; v[1] = 1; v[0] = 1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic compare(input string tag, input logic [3:0] got_s, input logic [16:0] got_o,
                         input logic [3:0] want_s);
    checks++;
    if (got_s === want_s) passes++;
    else $display("FAIL %s db_estado got %h want %h (t=%0t)", tag, got_s, want_s, $time);
    checks++;
    if (got_o === exp_out(want_s)) passes++;
    else $display("FAIL %s outputs got %b want %b (state %h, t=%0t)", tag, got_o,
                  exp_out(want_s), want_s, $time);
  endtask

  always @(posedge clock) begin
    #2;
    if (q0.size() > 0) compare("dut0", st0, o0, q0.pop_front());
    if (q1.size() > 0) compare("dut1_notimeout", st1, o1, q1.pop_front());
  end

  always @(async_ev) begin
    #1;
    if (q0.size() > 0) compare("async_reset", st0, o0, q0.pop_front());
  end

  task automatic clr();
    jogar = 0; jogada_feita = 0; jogada_correta = 0; eq = 0;
    fimCR = 0; fimL = 0; timeout = 0;
    jogar1 = 0; timeout1 = 0; fimL1 = 0; eq1 = 0;
  endtask

  task automatic tick(input logic [3:0] st);
    q0.push_back(st);
    @(negedge clock);
    clr();
  endtask

  task automatic tick1(input logic [3:0] st);
    q1.push_back(st);
    @(negedge clock);
    clr();
  endtask

  task automatic start();
    jogar = 1; tick(4'h1);
    tick(4'h2);
  endtask

  // Enter in state 2; leave in state 7 after r+1 LEDs were shown.
  task automatic replay(input int r, input int waits);
    for (int i = 0; i <= r; i++) begin
      tick(4'h3);
      for (int w = 0; w < waits; w++) tick(4'h3);
      fimL = 1; tick(4'h4);
      eq = (i == r);
      if (i == r) begin
        tick(4'h6);
      end else begin
        tick(4'h5);
        tick(4'h2);
      end
    end
    tick(4'h7);
  endtask

  // Enter in state 7; leave in 2 (next round), C (won) or D (wrong move).
  task automatic moves(input int r, input int wrong);
    for (int i = 0; i <= r; i++) begin
      if (i == 0) begin
        jogar = 1; tick(4'h7);
      end
      jogada_feita = 1; tick(4'h8);
      tick(4'h9);
      jogada_correta = (i != wrong); eq = (i == r); fimCR = (r == 15);
      if (i == wrong) begin
        tick(4'hD);
        return;
      end else if (i != r) begin
        tick(4'hA);
        tick(4'h7);
      end else if (r == 15) begin
        tick(4'hC);
      end else begin
        tick(4'hB);
        tick(4'h2);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1);
  end

  initial begin
    clr();
    reset = 0;
    #1;
    q0.push_back(4'h0);
    -> async_ev;
    @(negedge clock);
    @(negedge clock);
    reset = 1;
    tick(4'h0);

    // Full win: all 16 rounds, round 0 sees fimL after 5 cycles in espera_led.
    start();
    replay(0, 4);
    moves(0, -1);
    for (int r = 1; r < 16; r++) begin
      replay(r, 1);
      moves(r, -1);
    end
    tick(4'hC);

    // Restart from win, lose on the 3rd move of round 4.
    jogar = 1; tick(4'h1);
    tick(4'h2);
    for (int r = 0; r < 4; r++) begin
      replay(r, 0);
      moves(r, -1);
    end
    replay(4, 0);
    moves(4, 2);
    tick(4'hD);

    // Restart, then reset mid-replay while in espera_led.
    start();
    tick(4'h3);
    reset = 0;
    q0.push_back(4'h0);
    -> async_ev;
    tick(4'h0);
    tick(4'h0);
    reset = 1;
    tick(4'h0);

    // Timeout ends the game; then timeout coinciding with a move loses to the move.
    start();
    replay(0, 0);
    timeout = 1; tick(4'hE);
    tick(4'hE);
    start();
    replay(0, 0);
    timeout = 1; jogada_feita = 1; tick(4'h8);
    tick(4'h9);
    jogada_correta = 1; eq = 1; tick(4'hB);
    tick(4'h2);

    // Instance with the timeout disabled stays waiting for a move.
    jogar1 = 1; tick1(4'h1);
    tick1(4'h2);
    tick1(4'h3);
    fimL1 = 1; tick1(4'h4);
    eq1 = 1; tick1(4'h6);
    tick1(4'h7);
    for (int k = 0; k < 100; k++) begin
      timeout1 = 1; tick1(4'h7);
    end

    @(posedge clock);
    #3;
    checks++;
    if (q0.size() == 0 && q1.size() == 0) passes++;
    else $display("FAIL scoreboard_drain pending %0d/%0d want 0/0", q0.size(), q1.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
